// File: rtl/xc_malu_divrem_seq.sv
// Radix-2 restoring divide/remainder for RISC-V div/divu/rem/remu, one quotient bit per cycle.
// 32 cycles accept-to-valid (1 for divide-by-zero/overflow); result held while out_ready is low.
module xc_malu_divrem_seq (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        op_signed,
  input  logic        op_rem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] div_q;
  logic [5:0]  count;
  logic        rem_sel;
  logic        neg_q;
  logic        neg_r;
  logic        special;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        ovf;
  logic [32:0] trial;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  assign in_ready = (state == IDLE) && !flush;

  always_comb begin
    a_mag    = (op_signed && rs1[31]) ? -rs1 : rs1;
    b_mag    = (op_signed && rs2[31]) ? -rs2 : rs2;
    div_zero = (rs2 == 32'h0);
    ovf      = op_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    trial    = {rem_q, quo_q[31]} - {1'b0, div_q};
    if (!trial[32]) begin
      rem_next = trial[31:0];
      quo_next = {quo_q[30:0], 1'b1};
    end else begin
      rem_next = {rem_q[30:0], quo_q[31]};
      quo_next = {quo_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= 32'h0;
      rem_q     <= 32'h0;
      quo_q     <= 32'h0;
      div_q     <= 32'h0;
      count     <= 6'd0;
      rem_sel   <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem_sel <= op_rem;
            neg_q   <= op_signed & (rs1[31] ^ rs2[31]);
            neg_r   <= op_signed & rs1[31];
            rem_q   <= 32'h0;
            quo_q   <= a_mag;
            div_q   <= b_mag;
            count   <= 6'd0;
            special <= div_zero | ovf;
            // Special results are loaded now and surface one edge later, skipping the iterations.
            if (div_zero)
              result <= op_rem ? rs1 : 32'hFFFF_FFFF;
            else if (ovf)
              result <= op_rem ? 32'h0 : 32'h8000_0000;
            state   <= CALC;
          end
        end
        CALC: begin
          if (special) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count + 6'd1;
            if (count == 6'd31) begin
              result    <= rem_sel ? (neg_r ? -rem_next : rem_next)
                                   : (neg_q ? -quo_next : quo_next);
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_divrem_seq.sv
// Directed and random divide/remainder checks against an arithmetic reference model.
module tb_xc_malu_divrem_seq;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        op_signed = 1'b0;
  logic        op_rem = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  xc_malu_divrem_seq dut (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rs1      (rs1),
    .rs2      (rs2),
    .op_signed(op_signed),
    .op_rem   (op_rem),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic r);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0)
      return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return r ? 32'h0 : 32'h8000_0000;
    if (s)
      return r ? 32'(sa % sb) : 32'(sa / sb);
    return r ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 32'h0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      return 1;
    return 32;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
    @(negedge g_clk);
    rs1 = a; rs2 = b; op_signed = s; op_rem = r; in_valid = 1'b1;
    check("in_ready_before_accept", {31'h0, in_ready}, 32'h1);
    @(posedge g_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge g_clk);
      n++;
      @(negedge g_clk);
      if (out_valid) break;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic r);
    int n;
    start_op(a, b, s, r);
    wait_valid(n);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat(a, b, s)));
    check({tag, "_result"}, result, model(a, b, s, r));
    @(posedge g_clk);
    @(negedge g_clk);
    check({tag, "_valid_drop"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_ready_back"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);

    run("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    run("remu_100_7", 32'd100, 32'd7, 1'b0, 1'b1);
    run("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    run("div_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run("divu_by0", 32'd5, 32'd0, 1'b0, 1'b0);
    run("remu_by0", 32'd5, 32'd0, 1'b0, 1'b1);
    run("div_by0", 32'd5, 32'd0, 1'b1, 1'b0);
    run("rem_by0", 32'd5, 32'd0, 1'b1, 1'b1);
    run("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run("divu_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("remu_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Backpressure: result held, no new accept while DONE.
    out_ready = 1'b0;
    start_op(32'd1000, 32'd33, 1'b0, 1'b0);
    wait_valid(n);
    check("bp_latency", 32'(n), 32'd32);
    held = result;
    check("bp_result", held, 32'd30);
    rs1 = 32'd9; rs2 = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      check("bp_hold_result", result, held);
      check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    check("bp_release_valid", {31'h0, out_valid}, 32'h0);
    check("bp_release_ready", {31'h0, in_ready}, 32'h1);
    check("bp_release_result", result, held);

    // Flush mid-calculation.
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b1;
    @(posedge g_clk);
    #1 flush = 1'b0;
    @(negedge g_clk);
    check("flush_in_ready", {31'h0, in_ready}, 32'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge g_clk);
      if (out_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    run("after_flush", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);

    // Reset mid-calculation.
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    repeat (10) @(posedge g_clk);
    @(negedge g_clk);
    g_reset = 1'b1;
    @(posedge g_clk);
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_ready", {31'h0, in_ready}, 32'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge g_clk);
      if (out_valid) seen++;
    end
    check("rst_no_valid", 32'(seen), 32'd0);
    run("after_reset", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);

    // Random operands, with small and zero divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = b >> $urandom_range(0, 31);
        2: if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
        default: ;
      endcase
      run("rand", a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xc_malu_divrem_seq.md
# xc_malu_divrem_seq

Iterative 32-bit divide/remainder unit: the inverse of the MALU shift-add multiplier step. Implements RISC-V `div`, `divu`, `rem` and `remu` with a radix-2 restoring algorithm, one quotient bit per cycle. Sits beside the multiplier in the MALU and presents a valid/ready request and response pair to the issue stage. Owns its own state machine, iteration counter and operand/result registers.

## Interface

Parameters: none.

Ports:
- `g_clk`  in  1  clock; all state changes on the rising edge.
- `g_reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort the current operation and return to IDLE.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  high when the block can accept a request: `state==IDLE && !flush`.
- `rs1`  in  32  dividend.
- `rs2`  in  32  divisor.
- `op_signed`  in  1  1 = signed (`div`/`rem`), 0 = unsigned.
- `op_rem`  in  1  1 = return remainder, 0 = return quotient.
- `out_valid`  out  1  result valid; held until it is accepted.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  32  quotient or remainder, registered.

## Operation

- States:
  - IDLE: waits for a request.
  - CALC: runs the iterations.
  - DONE: presents the result.
- Accept: `in_valid && in_ready` at a rising edge. Latch `op_signed`, `op_rem`, `neg_q = op_signed & (rs1[31]^rs2[31])` and `neg_r = op_signed & rs1[31]`. Latch operand magnitudes: `|rs1|` and `|rs2|` when signed, raw values otherwise.
- Special cases are detected at accept and go straight to DONE with no iterations:
  - `rs2==0`: quotient `0xFFFFFFFF`; remainder `rs1` (unmodified).
  - Signed `rs1==0x80000000 && rs2==0xFFFFFFFF`: quotient `0x80000000`; remainder 0.
- Normal path, from IDLE to CALC:
  - Clear the 33-bit partial remainder `R` and the 6-bit counter.
  - Load `Q` with the dividend magnitude.
- Each CALC cycle:
  - `T = {R[31:0], Q[31]} - {1'b0, D}`.
  - If `T[32]==0`: `R = T` and `Q = {Q[30:0],1}`.
  - Else: `R = {R[31:0],Q[31]}` and `Q = {Q[30:0],0}`.
  - Increment the counter.
- On the cycle where `count==31`, the iteration completes and the design moves to DONE. `result` is loaded with:
  - `op_rem ? (neg_r ? -R[31:0] : R[31:0])`
  - `: (neg_q ? -Q_next : Q_next)`
- DONE: `out_valid=1` and `result` is stable. On `out_valid && out_ready` move to IDLE. `result` keeps its value until the next load.
- `flush` in any state forces IDLE on the next edge and drops `out_valid`. A request offered in the same cycle as `flush` is not accepted, because `in_ready` is 0.
- `g_reset` has priority over `flush` and over all other inputs.
- No accept is possible in the same cycle as result hand-off: `in_ready` rises the cycle after the DONE to IDLE transition.

## Timing

- Reset values: state IDLE, `out_valid=0`, `result=0`, counter 0, `in_ready=1` (when `flush=0`).
- Normal latency: accept on edge E0. Iterations on E1..E32. `out_valid` is high after E32, giving 32 cycles from accept to valid.
- Special-case latency: `out_valid` is high after E1.
- Throughput with `out_ready` tied high: one operation per 34 cycles (accept, 32 CALC cycles, DONE, IDLE).
- Backpressure: `out_valid` and `result` are held indefinitely while `out_ready=0`.
- Reset or flush during CALC: no `out_valid` pulse is ever produced for the aborted operation.
- The counter saturates at nothing: it is only meaningful in CALC and is cleared on accept.

## Test plan

- Unsigned `rs1=100`, `rs2=7`, `op_rem=0` → `result=14`, `out_valid` 32 cycles after accept. Repeat with `op_rem=1` → `result=2`.
- Signed `rs1=0xFFFFFFF9` (-7), `rs2=2`:
  - `op_rem=0` → `0xFFFFFFFD` (-3).
  - `op_rem=1` → `0xFFFFFFFF` (-1).
  - `rs2=0xFFFFFFFE` (-2), `op_rem=0` → `3`.
- Divide by zero, `rs1=5`, `rs2=0`, signed and unsigned:
  - quotient → `0xFFFFFFFF`.
  - remainder → `5`.
  - `out_valid` one cycle after accept.
- Signed overflow `0x80000000 / 0xFFFFFFFF` → quotient `0x80000000`, remainder `0`, 1-cycle latency. The same operands unsigned → quotient `0`, remainder `0x80000000`, 32-cycle latency.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid`. Require `result` stable, `in_ready=0`, and a new `in_valid` ignored. Release `out_ready` → IDLE next cycle, `in_ready=1`.
- Abort:
  - Assert `flush` at CALC iteration 10 → `out_valid` never rises and `in_ready=1` next cycle. A following `0xFFFFFFFF/0x10` unsigned request returns `0x0FFFFFFF`.
  - Repeat with `g_reset` instead of `flush` → all outputs return to their reset values.
